// File: rtl/qfix_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package     : qfix_pkg                                               |
// | Description : Shared sign-magnitude fixed-point constants and the    |
// |               divider state encoding (used by qdiv_seq and the       |
// |               companion multiplier).                                 |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package qfix_pkg;

  // Default word format: N bits total, bit N-1 is the sign, Q fraction bits
  localparam int QFIX_N = 32;
  localparam int QFIX_Q = 15;

  // All-ones magnitude used for saturation at the default width
  localparam logic [QFIX_N-2:0] QMAG_MAX = '1;

  // Number of shift-subtract iterations: width of |dividend| << Q
  localparam int QDIV_ITER = QFIX_N - 1 + QFIX_Q;

  // Divider controller states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIVIDE = 2'd1,
    DONE   = 2'd2
  } qdiv_state_t;

  // Iteration count for an arbitrary word format
  function automatic int qdiv_iter(input int n, input int q);
    return n - 1 + q;
  endfunction

endpackage
`default_nettype wire

// File: rtl/qdiv_seq_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Interface   : qdiv_seq_if                                            |
// | Description : Start/busy/done handshake and operand/result bus of    |
// |               the sequential fixed-point divider.                    |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
interface qdiv_seq_if
  import qfix_pkg::*;
#(
  parameter int N = QFIX_N
);

  logic         i_start;
  logic [N-1:0] i_dividend;
  logic [N-1:0] i_divisor;
  logic [N-1:0] o_quotient;
  logic         o_busy;
  logic         o_done;
  logic         o_ovr;

  // Requester side: issues operands and start, observes the result
  modport master (
    output i_start, i_dividend, i_divisor,
    input  o_quotient, o_busy, o_done, o_ovr
  );

  // Divider side
  modport slave (
    input  i_start, i_dividend, i_divisor,
    output o_quotient, o_busy, o_done, o_ovr
  );

endinterface
`default_nettype wire

// File: rtl/qdiv_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : qdiv_seq                                               |
// | Description : Sequential sign-magnitude fixed-point divider using    |
// |               restoring shift-subtract, one quotient bit per clock.  |
// |               Optional macro QDIV_ROUND_EN adds round-half-away-     |
// |               from-zero on the magnitude (default: truncation).      |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module qdiv_seq
  import qfix_pkg::*;
#(
  parameter int N = QFIX_N,
  parameter int Q = QFIX_Q
) (
  input wire        i_clk,
  input wire        i_rst_n,
  qdiv_seq_if.slave bus
);

  localparam int                 c_W        = qdiv_iter(N, Q);
  localparam int                 c_CNT_W    = $clog2(c_W);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(c_W - 1);
  localparam logic [N-2:0]       c_MAG_MAX  = '1;

  qdiv_state_t r_state;
  qdiv_state_t w_state_nxt;

  logic               r_sign;
  logic               r_dbz;
  logic [N-2:0]       r_dvs;
  logic [c_W-1:0]     r_dvd;
  logic [N-2:0]       r_rem;
  logic [c_W-1:0]     r_quo;
  logic [c_CNT_W-1:0] r_cnt;
  logic [N-1:0]       r_quotient;
  logic               r_done;
  logic               r_ovr;

  logic         w_start_ok;
  logic         w_dvs_zero;
  logic         w_load;
  logic         w_step;
  logic         w_finish;
  logic         w_busy;
  logic [N-1:0] w_rem_sh;
  logic         w_ge;
  logic [N-2:0] w_rem_sub;
  logic         w_hi_ovr;
  logic [N-2:0] w_mag;
  logic         w_ovr;
  logic         w_sign_out;

  // A start coinciding with the done pulse is deliberately ignored
  assign w_start_ok = bus.i_start & ~r_done;
  assign w_dvs_zero = (bus.i_divisor[N-2:0] == '0);

  // One restoring step: shift in the next dividend bit, subtract if it fits
  assign w_rem_sh  = {r_rem, r_dvd[c_W-1]};
  assign w_ge      = (w_rem_sh >= {1'b0, r_dvs});
  assign w_rem_sub = w_rem_sh[N-2:0] - r_dvs;

  // Any raw quotient bit above the magnitude field means overflow
  assign w_hi_ovr  = |r_quo[c_W-1:N-1];

`ifdef QDIV_ROUND_EN
  logic         w_round_up;
  logic [N-1:0] w_mag_inc;
  assign w_round_up = ({r_rem, 1'b0} >= {1'b0, r_dvs});
  assign w_mag_inc  = {1'b0, r_quo[N-2:0]} + {{(N-1){1'b0}}, w_round_up};
`endif

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state decode
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_start_ok) w_state_nxt = w_dvs_zero ? DONE : DIVIDE;
      DIVIDE:  if (r_cnt == c_CNT_LAST) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // State-derived controls for the datapath and the busy flag
  always_comb begin
    w_load   = 1'b0;
    w_step   = 1'b0;
    w_finish = 1'b0;
    w_busy   = 1'b0;
    case (r_state)
      IDLE:    w_load = w_start_ok;
      DIVIDE:  begin w_step = 1'b1;   w_busy = 1'b1; end
      DONE:    begin w_finish = 1'b1; w_busy = 1'b1; end
      default: ;
    endcase
  end

  // Saturation, optional rounding and zero-sign cleanup of the raw quotient
  always_comb begin
    w_ovr = 1'b0;
    w_mag = r_quo[N-2:0];
    if (r_dbz || w_hi_ovr) begin
      w_ovr = 1'b1;
      w_mag = c_MAG_MAX;
    end else begin
`ifdef QDIV_ROUND_EN
      if (w_mag_inc[N-1]) begin
        w_ovr = 1'b1;
        w_mag = c_MAG_MAX;
      end else begin
        w_mag = w_mag_inc[N-2:0];
      end
`else
      w_mag = r_quo[N-2:0];
`endif
    end
    w_sign_out = r_sign & (w_mag != '0);
  end

  // Operand capture and shift-subtract iteration
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sign <= 1'b0;
      r_dbz  <= 1'b0;
      r_dvs  <= '0;
      r_dvd  <= '0;
      r_rem  <= '0;
      r_quo  <= '0;
      r_cnt  <= '0;
    end else if (w_load) begin
      r_sign <= bus.i_dividend[N-1] ^ bus.i_divisor[N-1];
      r_dbz  <= w_dvs_zero;
      r_dvs  <= bus.i_divisor[N-2:0];
      r_dvd  <= {bus.i_dividend[N-2:0], {Q{1'b0}}};
      r_rem  <= '0;
      r_quo  <= '0;
      r_cnt  <= '0;
    end else if (w_step) begin
      r_dvd  <= r_dvd << 1;
      r_rem  <= w_ge ? w_rem_sub : w_rem_sh[N-2:0];
      r_quo  <= {r_quo[c_W-2:0], w_ge};
      r_cnt  <= r_cnt + c_CNT_W'(1);
    end
  end

  // Result registers: updated once per division, done pulses for one cycle
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_quotient <= '0;
      r_ovr      <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= w_finish;
      if (w_finish) begin
        r_quotient <= {w_sign_out, w_mag};
        r_ovr      <= w_ovr;
      end
    end
  end

  assign bus.o_quotient = r_quotient;
  assign bus.o_busy     = w_busy;
  assign bus.o_done     = r_done;
  assign bus.o_ovr      = r_ovr;

endmodule
`default_nettype wire

// File: tb/tb_qdiv_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_qdiv_seq                                            |
// | Description : Self-checking bench for qdiv_seq against an arithmetic |
// |               reference model (QDIV_ROUND_EN selects rounding).      |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_qdiv_seq;
  import qfix_pkg::*;

  localparam int N       = 32;
  localparam int Q       = 15;
  localparam int LAT_DIV = N + Q;
  localparam int LAT_DBZ = 1;
  localparam int LIMIT   = 200;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  qdiv_seq_if #(.N(N)) bus();

  qdiv_seq #(.N(N), .Q(Q)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Reference: real-valued division on magnitudes using 64-bit integers
  function automatic void model(input logic [N-1:0] a, input logic [N-1:0] b,
                                output logic [N-1:0] q, output logic ovr);
    longint unsigned num, den, quo, rem, maxm;
    logic sgn;
    maxm = (64'd1 << (N - 1)) - 64'd1;
    num  = 64'(a[N-2:0]) << Q;
    den  = 64'(b[N-2:0]);
    sgn  = a[N-1] ^ b[N-1];
    if (den == 0) begin
      quo = maxm;
      ovr = 1'b1;
    end else begin
      quo = num / den;
      rem = num % den;
`ifdef QDIV_ROUND_EN
      if (2 * rem >= den) quo = quo + 1;
`endif
      if (quo > maxm) begin
        quo = maxm;
        ovr = 1'b1;
      end else begin
        ovr = 1'b0;
      end
    end
    q = {(quo != 0) ? sgn : 1'b0, quo[N-2:0]};
  endfunction

  // Issue one start and wait (bounded) for done; lat counts edges after acceptance
  task automatic run_div(input logic [N-1:0] a, input logic [N-1:0] b,
                         output logic [N-1:0] q, output logic ovr, output int lat);
    @(negedge clk);
    bus.i_start    = 1'b1;
    bus.i_dividend = a;
    bus.i_divisor  = b;
    @(negedge clk);
    bus.i_start = 1'b0;
    lat = 0;
    while (bus.o_done !== 1'b1 && lat < LIMIT) begin
      @(negedge clk);
      lat++;
    end
    q   = bus.o_quotient;
    ovr = bus.o_ovr;
  endtask

  task automatic test_reset();
    bus.i_start    = 1'b0;
    bus.i_dividend = '0;
    bus.i_divisor  = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.o_quotient !== '0) begin errors++; $display("FAIL reset_quotient got %h want 0", bus.o_quotient); end
    checks++;
    if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.o_busy); end
    checks++;
    if (bus.o_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", bus.o_done); end
    checks++;
    if (bus.o_ovr !== 1'b0) begin errors++; $display("FAIL reset_ovr got %b want 0", bus.o_ovr); end
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    logic [N-1:0] ta [6];
    logic [N-1:0] tb [6];
    logic [N-1:0] tq [6];
    logic         to [6];
    int           tl [6];
    logic [N-1:0] q;
    logic         ovr;
    int           lat;
    ta[0] = 32'h00018000; tb[0] = 32'h00010000; tq[0] = 32'h0000C000; to[0] = 1'b0; tl[0] = LAT_DIV;
    ta[1] = 32'h80018000; tb[1] = 32'h00010000; tq[1] = 32'h8000C000; to[1] = 1'b0; tl[1] = LAT_DIV;
    ta[2] = 32'h80000000; tb[2] = 32'h00008000; tq[2] = 32'h00000000; to[2] = 1'b0; tl[2] = LAT_DIV;
`ifdef QDIV_ROUND_EN
    ta[3] = 32'h00008000; tb[3] = 32'h00018000; tq[3] = 32'h00002AAB; to[3] = 1'b0; tl[3] = LAT_DIV;
`else
    ta[3] = 32'h00008000; tb[3] = 32'h00018000; tq[3] = 32'h00002AAA; to[3] = 1'b0; tl[3] = LAT_DIV;
`endif
    ta[4] = 32'h40000000; tb[4] = 32'h00004000; tq[4] = 32'h7FFFFFFF; to[4] = 1'b1; tl[4] = LAT_DIV;
    ta[5] = 32'h00008000; tb[5] = 32'h80000000; tq[5] = 32'hFFFFFFFF; to[5] = 1'b1; tl[5] = LAT_DBZ;
    for (int i = 0; i < 6; i++) begin
      run_div(ta[i], tb[i], q, ovr, lat);
      checks++;
      if (q !== tq[i]) begin errors++; $display("FAIL directed%0d_quotient got %h want %h", i, q, tq[i]); end
      checks++;
      if (ovr !== to[i]) begin errors++; $display("FAIL directed%0d_ovr got %b want %b", i, ovr, to[i]); end
      checks++;
      if (lat != tl[i]) begin errors++; $display("FAIL directed%0d_latency got %0d want %0d", i, lat, tl[i]); end
    end
  endtask

  task automatic test_random();
    logic [N-1:0] a, b, q, eq;
    logic         ovr, eovr;
    int           lat, elat;
    for (int i = 0; i < 25; i++) begin
      a = {1'($urandom_range(0, 1)), 31'($urandom >> $urandom_range(0, 30))};
      b = {1'($urandom_range(0, 1)), 31'($urandom >> $urandom_range(8, 31))};
      if (i % 8 == 7) b[N-2:0] = '0;
      model(a, b, eq, eovr);
      elat = (b[N-2:0] == '0) ? LAT_DBZ : LAT_DIV;
      run_div(a, b, q, ovr, lat);
      checks++;
      if (q !== eq) begin errors++; $display("FAIL random%0d_quotient %h/%h got %h want %h", i, a, b, q, eq); end
      checks++;
      if (ovr !== eovr) begin errors++; $display("FAIL random%0d_ovr %h/%h got %b want %b", i, a, b, ovr, eovr); end
      checks++;
      if (lat != elat) begin errors++; $display("FAIL random%0d_latency got %0d want %0d", i, lat, elat); end
    end
  endtask

  task automatic test_handshake();
    logic [N-1:0] a, b, eq;
    logic         eovr;
    int           lat;
    a = 32'h0012_3456;
    b = 32'h8000_9ABC;
    model(a, b, eq, eovr);
    @(negedge clk);
    bus.i_start    = 1'b1;
    bus.i_dividend = a;
    bus.i_divisor  = b;
    @(negedge clk);
    lat = 0;
    while (bus.o_done !== 1'b1 && lat < LIMIT) begin
      bus.i_dividend = $urandom;
      bus.i_divisor  = $urandom;
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat != LAT_DIV) begin errors++; $display("FAIL handshake_latency got %0d want %0d", lat, LAT_DIV); end
    checks++;
    if (bus.o_quotient !== eq) begin errors++; $display("FAIL handshake_quotient got %h want %h", bus.o_quotient, eq); end
    checks++;
    if (bus.o_ovr !== eovr) begin errors++; $display("FAIL handshake_ovr got %b want %b", bus.o_ovr, eovr); end
    bus.i_start = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.o_done !== 1'b0) begin errors++; $display("FAIL handshake_single_pulse got done=%b want 0", bus.o_done); end
    checks++;
    if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL handshake_idle_busy got %b want 0", bus.o_busy); end
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] a, b, qa, qb, ea, eb;
    logic         oa, ob, eoa, eob;
    int           lat;
    a = 32'h0003_0000;
    b = 32'h0000_A000;
    model(a, b, ea, eoa);
    run_div(a, b, qa, oa, lat);
    checks++;
    if (qa !== ea) begin errors++; $display("FAIL b2b_first_quotient got %h want %h", qa, ea); end
    // Start raised during the done cycle must be ignored for that edge
    bus.i_start    = 1'b1;
    bus.i_dividend = 32'h8007_0000;
    bus.i_divisor  = 32'h0001_8000;
    model(bus.i_dividend, bus.i_divisor, eb, eob);
    @(negedge clk);
    checks++;
    if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL b2b_ignored_busy got %b want 0", bus.o_busy); end
    checks++;
    if (bus.o_quotient !== ea) begin errors++; $display("FAIL b2b_held_quotient got %h want %h", bus.o_quotient, ea); end
    @(negedge clk);
    bus.i_start = 1'b0;
    checks++;
    if (bus.o_busy !== 1'b1) begin errors++; $display("FAIL b2b_accept_busy got %b want 1", bus.o_busy); end
    lat = 0;
    while (bus.o_done !== 1'b1 && lat < LIMIT) begin
      @(negedge clk);
      lat++;
    end
    qb = bus.o_quotient;
    ob = bus.o_ovr;
    checks++;
    if (lat != LAT_DIV) begin errors++; $display("FAIL b2b_latency got %0d want %0d", lat, LAT_DIV); end
    checks++;
    if (qb !== eb) begin errors++; $display("FAIL b2b_second_quotient got %h want %h", qb, eb); end
    checks++;
    if (ob !== eob) begin errors++; $display("FAIL b2b_second_ovr got %b want %b", ob, eob); end
  endtask

  task automatic test_mid_reset();
    logic [N-1:0] q, eq;
    logic         ovr, eovr;
    int           lat, pulses;
    // Leave a nonzero, overflowed result behind so the reset clearing is visible
    run_div(32'h40000000, 32'h00004000, q, ovr, lat);
    @(negedge clk);
    bus.i_start    = 1'b1;
    bus.i_dividend = 32'h0001_8000;
    bus.i_divisor  = 32'h0001_0000;
    @(negedge clk);
    bus.i_start = 1'b0;
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.o_quotient !== '0 || bus.o_ovr !== 1'b0 || bus.o_busy !== 1'b0 || bus.o_done !== 1'b0) begin
      errors++;
      $display("FAIL midreset_async got q=%h ovr=%b busy=%b done=%b want all 0",
               bus.o_quotient, bus.o_ovr, bus.o_busy, bus.o_done);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (bus.o_done === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 0) begin errors++; $display("FAIL midreset_no_done got %0d pulses want 0", pulses); end
    model(32'h8005_0000, 32'h0000_C000, eq, eovr);
    run_div(32'h8005_0000, 32'h0000_C000, q, ovr, lat);
    checks++;
    if (q !== eq) begin errors++; $display("FAIL midreset_after_quotient got %h want %h", q, eq); end
    checks++;
    if (lat != LAT_DIV) begin errors++; $display("FAIL midreset_after_latency got %0d want %0d", lat, LAT_DIV); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_handshake();
    test_back_to_back();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/qdiv_seq.md
Name: qdiv_seq

Overview:
- Sequential fixed-point divider; inverse operation of the team's combinational sign-magnitude multiplier.
- Operand format is identical: sign-magnitude, N bits, Q fractional bits. Bit N-1 is the sign; bits N-2:0 are the magnitude.
- Uses restoring shift-subtract, one quotient bit per clock, with a start/busy/done handshake.
- Sits beside the multiplier in the control-loop datapath, e.g. PID gain normalisation and odometry scaling.

Parameters:
- Q, 15, number of fractional bits (operands and result).
- N, 32, total word width including the sign bit.

Ports:
- i_clk, in, 1, system clock; all state changes on the rising edge.
- i_rst_n, in, 1, asynchronous active-low reset.
- i_start, in, 1, begin a division; sampled only in IDLE.
- i_dividend, in, N, sign-magnitude numerator; captured on the accepted start.
- i_divisor, in, N, sign-magnitude denominator; captured on the accepted start.
- o_quotient, out, N, sign-magnitude result; held until the next accepted start.
- o_busy, out, 1, high from the accepted start until o_done.
- o_done, out, 1, single-cycle pulse when o_quotient and o_ovr are valid.
- o_ovr, out, 1, overflow or divide-by-zero flag; valid with o_done and held with o_quotient.

Behaviour:
- Clock and reset (already decided): one clock, i_clk. i_rst_n is asynchronous and active-low.
- Reset values: o_quotient=0, o_busy=0, o_done=0, o_ovr=0, state=IDLE, all internal registers 0.
- States are IDLE, DIVIDE and DONE.
- IDLE:
  - i_start=1 with divisor magnitude nonzero: latch operands and sign = dividend[N-1]^divisor[N-1]; load the working dividend as |dividend| << Q (width N-1+Q); clear remainder and iteration counter; o_busy=1; go to DIVIDE.
  - i_start=1 with divisor magnitude 0: latch sign; go straight to DONE with the divide-by-zero result.
- DIVIDE:
  - Each cycle: shift the remainder left 1, bringing in the next working-dividend MSB.
  - If remainder >= |divisor|, subtract and shift a 1 into the quotient; otherwise shift in a 0.
  - Runs exactly N-1+Q cycles, then goes to DONE.
- DONE (one cycle):
  - o_done=1 and o_busy=0; register the result; return to IDLE.
  - Raw quotient is N-1+Q bits wide.
  - If any of raw bits [N-2+Q:N-1] are set: o_ovr=1 and the magnitude saturates to all ones.
  - Otherwise: magnitude = raw[N-2:0], o_ovr=0.
  - Divide-by-zero: magnitude all ones, o_ovr=1.
  - If the final magnitude is 0, the sign bit is forced to 0 (no negative zero).
- Latency:
  - Normal division: o_done asserts N+Q cycles after the accepted start edge (47 cycles at defaults).
  - Divide-by-zero: o_done asserts 1 cycle after the start edge.
- Back-to-back: i_start may be asserted in the same cycle o_done=1. It is ignored; it is accepted on the following IDLE cycle.
- i_start while o_busy=1 is ignored; operand changes while busy have no effect.
- Reset mid-operation returns immediately to IDLE with reset values. No o_done is produced for the aborted division.
- Truncation is toward zero in magnitude, except when the optional rounding feature is compiled in.

Optional Feature:
- Macro: QDIV_ROUND_EN.
- Defined:
  - DONE uses one extra compare: if 2*remainder >= |divisor|, magnitude is incremented (round half away from zero, applied to the magnitude).
  - A carry out of N-1 bits sets o_ovr and saturates the magnitude.
  - Latency is unchanged.
- Undefined: truncated result, no increment logic.

Decomposition:
- Shared package qfix_pkg holds:
  - default N and Q constants, shared with the multiplier;
  - the state enum (IDLE, DIVIDE, DONE);
  - localparam QMAG_MAX, the all-ones magnitude;
  - the iteration-count constant N-1+Q.
- No sub-module: a single shift-subtract datapath plus a 3-state FSM. Splitting it adds ports without reuse.

Test Plan:
- 3.0/2.0: dividend 0x00018000, divisor 0x00010000 -> o_quotient 0x0000C000, o_ovr=0, o_done 47 cycles after start.
- -3.0/2.0: dividend 0x80018000, divisor 0x00010000 -> 0x8000C000. Then -0.0 result check: dividend 0x80000000, divisor 0x00008000 -> 0x00000000.
- 1.0/3.0: dividend 0x00008000, divisor 0x00018000 -> 0x00002AAA truncated; 0x00002AAB with QDIV_ROUND_EN.
- Overflow: 0x40000000/0x00004000 -> o_quotient 0x7FFFFFFF, o_ovr=1. Divide-by-zero: 0x00008000/0x80000000 -> 0xFFFFFFFF, o_ovr=1, o_done 1 cycle after start.
- Handshake: i_start pulsed every cycle with changing operands during a division -> the first operands' result is unchanged and exactly one o_done pulse per accepted start.
- Reset mid-operation: i_rst_n low at cycle 20 of DIVIDE -> all outputs 0 asynchronously, no o_done. A new start after release -> correct result.
